// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  // ACCESS_CYCLES may be at most 15, so a 4-bit counter always suffices.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  typedef enum logic {
    G_WR = 1'b0,
    G_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between a write port and a read port, with round-robin arbitration.
// Latency: req first high at edge N with no contention -> ack pulses in cycle N+1+ACCESS_CYCLES.
// Backpressure: req/ack handshake. A requester holds req, addr and data until its one-cycle ack.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_wr_req/addr/data      write request (held until o_wr_ack)
//   i_rd_req/addr           read request (held until o_rd_ack)
//   o_wr_ack, o_rd_ack      one-cycle completion pulses
//   o_rd_data               last read data, held until the next read completes
//   o_busy                  high while an access owns the bus
//   o_SRAM_*, io_SRAM_DQ    SRAM pins. DQ is driven only during WRITE.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  grant_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_ack_q, rd_ack_q;

  logic              wr_elig, rd_elig;
  logic              take_wr, take_rd;
  logic              wr_done, rd_done;

  // A requester sees its ack in the same cycle that it may still hold req.
  // Masking that cycle keeps the same request from being granted twice.
  assign wr_elig = i_wr_req && !wr_ack_q;
  assign rd_elig = i_rd_req && !rd_ack_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= G_WR;   // a read wins the first contested grant
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      wr_ack_q <= wr_done;
      rd_ack_q <= rd_done;
      if (take_wr) begin
        addr_q  <= i_wr_addr;
        wdata_q <= i_wr_data;
      end
      if (take_rd) begin
        addr_q <= i_rd_addr;
      end
      // Capture on the final edge of the read, while OE_N is still low.
      if (rd_done) begin
        rd_data_q <= io_SRAM_DQ;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    take_wr = 1'b0;
    take_rd = 1'b0;
    wr_done = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The write wins if it is alone or if the read had the last grant.
        if (wr_elig && (!rd_elig || last_q == G_RD)) begin
          take_wr = 1'b1;
          state_d = S_WRITE;
          cnt_d   = '0;
          last_d  = G_WR;
        end else if (rd_elig) begin
          take_rd = 1'b1;
          state_d = S_READ;
          cnt_d   = '0;
          last_d  = G_RD;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
          wr_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_READ: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
          rd_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register. Async reset therefore
  // releases them, and DQ, without waiting for a clock edge.
  always_comb begin
    o_SRAM_WE_N = 1'b1;
    o_SRAM_CE_N = 1'b1;
    o_SRAM_OE_N = 1'b1;
    o_SRAM_LB_N = 1'b1;
    o_SRAM_UB_N = 1'b1;
    case (state_q)
      S_WRITE: begin
        o_SRAM_CE_N = 1'b0;
        o_SRAM_WE_N = 1'b0;
        o_SRAM_LB_N = 1'b0;
        o_SRAM_UB_N = 1'b0;
      end
      S_READ: begin
        o_SRAM_CE_N = 1'b0;
        o_SRAM_OE_N = 1'b0;
        o_SRAM_LB_N = 1'b0;
        o_SRAM_UB_N = 1'b0;
      end
      default: ;
    endcase
  end

  // The ack cycle always passes through IDLE, so DQ has a turnaround cycle
  // between a write and any following read.
  assign io_SRAM_DQ  = (state_q == S_WRITE) ? wdata_q : {DATA_W{1'bz}};

  assign o_SRAM_ADDR = addr_q;
  assign o_rd_data   = rd_data_q;
  assign o_wr_ack    = wr_ack_q;
  assign o_rd_ack    = rd_ack_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with ACCESS_CYCLES=2, one with ACCESS_CYCLES=1.
// Each SRAM model drives DQ only while OE_N is low. Otherwise, while WE_N is high,
// it drives a canary value, so any stray drive from the DUT corrupts the bus.
module tb_sram_arbiter;

  localparam logic [15:0] CANARY = 16'h5A3C;
  localparam logic [4:0]  ST_IDLE  = 5'b11111;  // {we,ce,oe,lb,ub}
  localparam logic [4:0]  ST_WRITE = 5'b00100;
  localparam logic [4:0]  ST_READ  = 5'b10000;

  logic clk, rst;

  // instance 0 (ACCESS_CYCLES = 2)
  logic        wr_req, rd_req, wr_ack, rd_ack, busy;
  logic [19:0] wr_addr, rd_addr, sram_addr;
  logic [15:0] wr_data, rd_data;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;
  wire  [15:0] dq;
  logic [15:0] mem0 [256];

  // instance 1 (ACCESS_CYCLES = 1)
  logic        wr_req1, rd_req1, wr_ack1, rd_ack1, busy1;
  logic [19:0] wr_addr1, rd_addr1, sram_addr1;
  logic [15:0] wr_data1, rd_data1;
  logic        we_n1, ce_n1, oe_n1, lb_n1, ub_n1;
  wire  [15:0] dq1;
  logic [15:0] mem1 [256];

  int n_cmp = 0;
  int n_bad = 0;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_ack(rd_ack),
    .o_busy(busy), .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req1), .i_wr_addr(wr_addr1), .i_wr_data(wr_data1), .o_wr_ack(wr_ack1),
    .i_rd_req(rd_req1), .i_rd_addr(rd_addr1), .o_rd_data(rd_data1), .o_rd_ack(rd_ack1),
    .o_busy(busy1), .o_SRAM_ADDR(sram_addr1), .io_SRAM_DQ(dq1),
    .o_SRAM_WE_N(we_n1), .o_SRAM_CE_N(ce_n1), .o_SRAM_OE_N(oe_n1),
    .o_SRAM_LB_N(lb_n1), .o_SRAM_UB_N(ub_n1)
  );

  assign dq  = (!ce_n && !oe_n && we_n) ? mem0[sram_addr[7:0]] :
               (we_n ? CANARY : 16'hzzzz);
  assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? mem1[sram_addr1[7:0]] :
               (we_n1 ? CANARY : 16'hzzzz);

  always @(posedge clk) begin
    if (!ce_n && !we_n)   mem0[sram_addr[7:0]]  <= dq;
    if (!ce_n1 && !we_n1) mem1[sram_addr1[7:0]] <= dq1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic b, input logic [4:0] st,
                            input logic wa, input logic ra);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_strb"}, 32'({we_n, ce_n, oe_n, lb_n, ub_n}), 32'(st));
    check({tag, "_wack"}, 32'(wr_ack), 32'(wa));
    check({tag, "_rack"}, 32'(rd_ack), 32'(ra));
  endtask

  // Uncontended write with ACCESS_CYCLES=2: raised in cycle N, ack in cycle N+3.
  task automatic quick_write(input logic [19:0] a, input logic [15:0] d);
    step();
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    repeat (3) step();
    @(negedge clk);
    check("qw_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_req1 = 1'b0; rd_req1 = 1'b0; wr_addr1 = '0; rd_addr1 = '0; wr_data1 = '0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end

    // ---- reset values ----
    repeat (2) step();
    @(negedge clk);
    expect_cyc("rst", 1'b0, ST_IDLE, 1'b0, 1'b0);
    check("rst_rdata", 32'(rd_data), 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_dq", 32'(dq), 32'(CANARY));
    check("rst1_strb", 32'({we_n1, ce_n1, oe_n1, lb_n1, ub_n1}), 32'(ST_IDLE));
    step();
    rst = 1'b0;

    // ---- single write: 0x00010 <= 0xA5A5 ----
    step();                                          // cycle N
    wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 16'hA5A5;
    @(negedge clk); expect_cyc("w_n0", 1'b0, ST_IDLE, 1'b0, 1'b0);
    step();                                          // N+1
    @(negedge clk); expect_cyc("w_n1", 1'b1, ST_WRITE, 1'b0, 1'b0);
    check("w_n1_dq", 32'(dq), 32'hA5A5);
    check("w_n1_addr", 32'(sram_addr), 32'h00010);
    wr_addr = 20'h00099; wr_data = 16'hFFFF;         // must not disturb the access
    step();                                          // N+2
    @(negedge clk); expect_cyc("w_n2", 1'b1, ST_WRITE, 1'b0, 1'b0);
    check("w_n2_dq", 32'(dq), 32'hA5A5);
    check("w_n2_addr", 32'(sram_addr), 32'h00010);
    step();                                          // N+3
    @(negedge clk); expect_cyc("w_n3", 1'b0, ST_IDLE, 1'b1, 1'b0);
    check("w_n3_dq", 32'(dq), 32'(CANARY));
    wr_req = 1'b0;
    step();                                          // N+4
    @(negedge clk); expect_cyc("w_n4", 1'b0, ST_IDLE, 1'b0, 1'b0);
    check("w_n4_addr_hold", 32'(sram_addr), 32'h00010);

    // Leave different data in the write register so a stray drive during READ collides.
    quick_write(20'h00020, 16'h1234);

    // ---- read of 0x00010 ----
    step();                                          // N
    rd_req = 1'b1; rd_addr = 20'h00010;
    @(negedge clk); expect_cyc("r_n0", 1'b0, ST_IDLE, 1'b0, 1'b0);
    step();
    @(negedge clk); expect_cyc("r_n1", 1'b1, ST_READ, 1'b0, 1'b0);
    check("r_n1_dq", 32'(dq), 32'hA5A5);
    check("r_n1_addr", 32'(sram_addr), 32'h00010);
    step();
    @(negedge clk); expect_cyc("r_n2", 1'b1, ST_READ, 1'b0, 1'b0);
    check("r_n2_dq", 32'(dq), 32'hA5A5);
    step();
    @(negedge clk); expect_cyc("r_n3", 1'b0, ST_IDLE, 1'b0, 1'b1);
    check("r_n3_data", 32'(rd_data), 32'hA5A5);
    rd_req = 1'b0;
    step();
    @(negedge clk); expect_cyc("r_n4", 1'b0, ST_IDLE, 1'b0, 1'b0);
    check("r_n4_data_hold", 32'(rd_data), 32'hA5A5);

    // ---- contention just after reset: RD,WR,RD,WR,RD,WR with one IDLE between ----
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    step();                                          // cycle N
    wr_req = 1'b1; wr_addr = 20'h00030; wr_data = 16'hBEEF;
    rd_req = 1'b1; rd_addr = 20'h00010;
    for (int c = 1; c <= 18; c++) begin
      step();
      @(negedge clk);
      if (c % 3 == 0) begin
        check($sformatf("arb%0d_busy", c), 32'(busy), 32'd0);
        check($sformatf("arb%0d_rack", c), 32'(rd_ack), 32'(((c / 3) % 2) == 1));
        check($sformatf("arb%0d_wack", c), 32'(wr_ack), 32'(((c / 3) % 2) == 0));
        if ((c / 3) % 2 == 1) check($sformatf("arb%0d_rdata", c), 32'(rd_data), 32'hA5A5);
      end else begin
        check($sformatf("arb%0d_busy", c), 32'(busy), 32'd1);
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    @(negedge clk); expect_cyc("arb_end", 1'b0, ST_IDLE, 1'b0, 1'b0);

    // ---- req held one cycle past ack, then dropped: no second grant ----
    step();                                          // N
    wr_req = 1'b1; wr_addr = 20'h00050; wr_data = 16'h7777;
    repeat (3) step();                               // N+3
    @(negedge clk); check("hold_a_ack", 32'(wr_ack), 32'd1);
    step();                                          // N+4: req was still high at edge N+4
    wr_req = 1'b0;
    @(negedge clk); expect_cyc("hold_a_n4", 1'b0, ST_IDLE, 1'b0, 1'b0);
    step();
    @(negedge clk); expect_cyc("hold_a_n5", 1'b0, ST_IDLE, 1'b0, 1'b0);

    // ---- req held two cycles past ack: new access on the cycle after ack ----
    step();                                          // M
    wr_req = 1'b1;
    repeat (3) step();                               // M+3
    @(negedge clk); check("hold_b_ack", 32'(wr_ack), 32'd1);
    step();                                          // M+4
    @(negedge clk); expect_cyc("hold_b_m4", 1'b0, ST_IDLE, 1'b0, 1'b0);
    step();                                          // M+5
    wr_req = 1'b0;
    @(negedge clk); expect_cyc("hold_b_m5", 1'b1, ST_WRITE, 1'b0, 1'b0);
    step();
    @(negedge clk); check("hold_b_m6_busy", 32'(busy), 32'd1);
    step();
    @(negedge clk); expect_cyc("hold_b_m7", 1'b0, ST_IDLE, 1'b1, 1'b0);
    step();
    @(negedge clk); check("hold_b_m8_busy", 32'(busy), 32'd0);

    // ---- reset asserted during cnt=0 of a write ----
    step();                                          // N
    wr_req = 1'b1; wr_addr = 20'h00060; wr_data = 16'h1111;
    step();                                          // N+1, WRITE cnt=0
    @(negedge clk); check("mrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;                                              // no clock edge in between
    expect_cyc("mrst_async", 1'b0, ST_IDLE, 1'b0, 1'b0);
    check("mrst_dq", 32'(dq), 32'(CANARY));
    check("mrst_addr", 32'(sram_addr), 32'h0);
    wr_req = 1'b0;
    step();
    @(negedge clk); check("mrst_in_wack", 32'(wr_ack), 32'd0);
    step(); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      expect_cyc($sformatf("mrst_post%0d", c), 1'b0, ST_IDLE, 1'b0, 1'b0);
      step();
    end

    // ---- ACCESS_CYCLES=1: write then read, acks in N+2 and N+4 ----
    step();                                          // N
    wr_req1 = 1'b1; wr_addr1 = 20'h00040; wr_data1 = 16'h0F0F;
    @(negedge clk); check("ac1_n0_busy", 32'(busy1), 32'd0);
    step();                                          // N+1
    rd_req1 = 1'b1; rd_addr1 = 20'h00040;
    @(negedge clk);
    check("ac1_n1_busy", 32'(busy1), 32'd1);
    check("ac1_n1_strb", 32'({we_n1, ce_n1, oe_n1, lb_n1, ub_n1}), 32'(ST_WRITE));
    check("ac1_n1_dq", 32'(dq1), 32'h0F0F);
    step();                                          // N+2
    @(negedge clk);
    check("ac1_n2_wack", 32'(wr_ack1), 32'd1);
    check("ac1_n2_busy", 32'(busy1), 32'd0);
    wr_req1 = 1'b0;
    step();                                          // N+3
    @(negedge clk);
    check("ac1_n3_strb", 32'({we_n1, ce_n1, oe_n1, lb_n1, ub_n1}), 32'(ST_READ));
    check("ac1_n3_rack", 32'(rd_ack1), 32'd0);
    step();                                          // N+4
    @(negedge clk);
    check("ac1_n4_rack", 32'(rd_ack1), 32'd1);
    check("ac1_n4_rdata", 32'(rd_data1), 32'h0F0F);
    rd_req1 = 1'b0;
    step();
    @(negedge clk);
    check("ac1_n5_busy", 32'(busy1), 32'd0);
    check("ac1_n5_rack", 32'(rd_ack1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single off-chip SRAM (16-bit asynchronous) between two requesters: the recorder write port and the player/DSP read port.
- Sits between the top-level audio FSM datapath and the SRAM pins, and owns every SRAM control and data pin.
- Sequences each access as a fixed-length bus cycle.
- Uses round-robin arbitration when both ports request at once.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, clock cycles each SRAM access holds the bus; legal range 1..15.

Ports:
- i_clk  in  1  system clock (12 MHz audio clock domain).
- i_rst  in  1  asynchronous, active-high reset.
- i_wr_req  in  1  recorder write request; held high until o_wr_ack.
- i_wr_addr  in  ADDR_W  write address; stable while i_wr_req is high.
- i_wr_data  in  DATA_W  write data; stable while i_wr_req is high.
- o_wr_ack  out  1  one-cycle pulse: write completed.
- i_rd_req  in  1  player read request; held high until o_rd_ack.
- i_rd_addr  in  ADDR_W  read address; stable while i_rd_req is high.
- o_rd_data  out  DATA_W  read data; valid when o_rd_ack is high, held until the next read completes.
- o_rd_ack  out  1  one-cycle pulse: read data valid.
- o_busy  out  1  high while an access is in progress.
- o_SRAM_ADDR  out  ADDR_W  SRAM address.
- io_SRAM_DQ  inout  DATA_W  SRAM data bus; driven only during a write access.
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  SRAM strobes, active-low.

Behaviour:
- Clock and reset: single clock i_clk; i_rst is asynchronous, active-high.
- Values while in reset:
  - state IDLE.
  - o_wr_ack = 0, o_rd_ack = 0, o_busy = 0, o_rd_data = 0, o_SRAM_ADDR = 0.
  - All SRAM strobes = 1.
  - DQ tri-stated.
  - last_grant = WR, so a read wins the first contested arbitration.
- States: IDLE, WRITE, READ. A counter cnt runs 0..ACCESS_CYCLES-1.
- IDLE:
  - A request is eligible only if its req is high and its own ack is not high this cycle. This guards against re-granting a requester that has not yet dropped req.
  - Only the write request eligible: go to WRITE.
  - Only the read request eligible: go to READ.
  - Both eligible: grant the port that is not last_grant.
  - On every grant: latch the address (and write data) into registers, cnt = 0, update last_grant.
- WRITE:
  - CE_N = 0, WE_N = 0, OE_N = 1, LB_N = UB_N = 0.
  - DQ driven with the latched data; ADDR = latched address.
- READ:
  - CE_N = 0, OE_N = 0, WE_N = 1, LB_N = UB_N = 0.
  - DQ = Z; ADDR = latched address.
- Access completion:
  - When cnt == ACCESS_CYCLES-1: next edge returns to IDLE and pulses the matching ack for exactly 1 cycle.
  - For READ, o_rd_data registers io_SRAM_DQ on that same edge.
  - Otherwise cnt increments.
- Latency: req first high at edge N in IDLE with no contention → ack high in cycle N+1+ACCESS_CYCLES. Back-to-back throughput is one access per ACCESS_CYCLES+1 cycles.
- In IDLE, all strobes = 1 and DQ = Z. o_SRAM_ADDR keeps its last value.
- Bus contention: the arbiter never drives DQ in IDLE or READ. An IDLE cycle always separates WRITE from READ, which gives bus turnaround.
- o_busy is high exactly in WRITE/READ.
- Requester dropping req mid-access: the access still completes and the ack is still issued. The requester must ignore it.
- Changes to address or data during an access have no effect, because they were latched at grant.
- Reset asserted mid-access: immediate return to reset values, no ack issued, DQ released asynchronously.
- Both requests held high continuously: grants strictly alternate RD, WR, RD, WR… No starvation.

Decomposition:
- Package sram_arb_pkg:
  - state enum {S_IDLE, S_WRITE, S_READ}.
  - grant enum {G_WR, G_RD}.
  - Constants SRAM_ADDR_W = 20, SRAM_DATA_W = 16.
- No sub-module. Arbitration, sequencing and the DQ tri-state all live in this block; the tri-state stays at the level that owns the pins.

Test Plan:
- Reset release, then a single write (addr 0x00010, data 0xA5A5, ACCESS_CYCLES = 2) → WE_N/CE_N low for exactly 2 cycles, DQ = 0xA5A5, ADDR = 0x00010, o_wr_ack pulses in cycle N+3, DQ = Z afterward.
- A read of 0x00010 with the SRAM model returning 0xA5A5 → OE_N low 2 cycles, DQ never driven by the DUT, o_rd_ack 1 cycle with o_rd_data = 0xA5A5, data held after ack falls.
- Both requests raised on the same cycle right after reset → READ granted first, then WRITE; with both held for 6 grants, the order is RD,WR,RD,WR,RD,WR and each access is separated by exactly one IDLE cycle.
- A requester keeps req high for 1 cycle after its ack → no duplicate grant on the ack cycle; a new access is granted on the following cycle only if req is still high.
- i_rst asserted on cnt = 0 of a WRITE → strobes go high and DQ = Z without waiting for a clock edge, no o_wr_ack, state IDLE after release.
- ACCESS_CYCLES = 1 build: a write followed by a read takes 4 cycles total, and the acks land in cycles N+2 and N+4.
